// File: rtl/mem_dump_sequencer.sv
// Streams data memory words 0..last out of the debug read port as LSB-first bytes
// over a valid/ready link. Optional trailing XOR checksum byte: DUMP_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for a start; pointer and byte counter held at 0
// LOAD  | capture the word at the debug pointer
// SEND  | present byte cnt until the transmitter takes it
// NEXT  | stop at the latched last word, else advance the pointer
// CSUM  | present the XOR checksum byte (checksum build only)
// DONE  | one-cycle completion pulse, pointer back to 0
module mem_dump_sequencer #(
   parameter int TAM_DATA  = 32,
   parameter int NUM_BYTES = TAM_DATA / 8,
   parameter int NUM_DIREC = 7
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic [NUM_DIREC-1:0] i_last_addr,
   input  logic [TAM_DATA-1:0]  i_debug_read,
   output logic [NUM_DIREC-1:0] o_debug_pointer,
   output logic [7:0]           o_tx_data,
   output logic                 o_tx_valid,
   input  logic                 i_tx_ready,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SEND = 3'd2,
      ST_NEXT = 3'd3,
      ST_DONE = 3'd4
`ifdef DUMP_CHECKSUM_EN
      , ST_CSUM = 3'd5
`endif
   } state_t;

   state_t               state;
   logic [NUM_DIREC-1:0] ptr;
   logic [NUM_DIREC-1:0] last_addr;
   logic [TAM_DATA-1:0]  word;
   logic [CNT_W-1:0]     cnt;
   logic [7:0]           word_byte;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]           csum;
`endif

   always_comb begin
      word_byte = '0;
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (cnt == CNT_W'(b)) word_byte = word[8*b +: 8];
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         last_addr <= '0;
         word      <= '0;
         cnt       <= '0;
`ifdef DUMP_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               ptr <= '0;
               cnt <= '0;
               if (i_start) begin
                  last_addr <= i_last_addr;
`ifdef DUMP_CHECKSUM_EN
                  csum      <= '0;
`endif
                  state     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               word  <= i_debug_read;
               cnt   <= '0;
               state <= ST_SEND;
            end
            ST_SEND: begin
               if (i_tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
                  csum <= csum ^ word_byte;
`endif
                  if (cnt == CNT_W'(NUM_BYTES - 1)) state <= ST_NEXT;
                  else                              cnt   <= cnt + CNT_W'(1);
               end
            end
            ST_NEXT: begin
               // Compare before incrementing so a full-range dump never wraps.
               if (ptr == last_addr) begin
`ifdef DUMP_CHECKSUM_EN
                  state <= ST_CSUM;
`else
                  state <= ST_DONE;
`endif
               end else begin
                  ptr   <= ptr + NUM_DIREC'(1);
                  state <= ST_LOAD;
               end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CSUM: begin
               if (i_tx_ready) state <= ST_DONE;
            end
`endif
            ST_DONE: begin
               ptr   <= '0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_debug_pointer = ptr;
   assign o_busy          = (state != ST_IDLE);
   assign o_done          = (state == ST_DONE);
`ifdef DUMP_CHECKSUM_EN
   assign o_tx_valid = (state == ST_SEND) || (state == ST_CSUM);
   assign o_tx_data  = (state == ST_CSUM) ? csum : word_byte;
`else
   assign o_tx_valid = (state == ST_SEND);
   assign o_tx_data  = word_byte;
`endif

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Directed bench for mem_dump_sequencer; expectations follow DUMP_CHECKSUM_EN when defined.
module tb_mem_dump_sequencer;

   localparam int TAM_DATA  = 32;
   localparam int NUM_BYTES = 4;
   localparam int NUM_DIREC = 7;
`ifdef DUMP_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic                 i_clk = 1'b0;
   logic                 i_reset = 1'b0;
   logic                 i_start = 1'b0;
   logic [NUM_DIREC-1:0] i_last_addr = '0;
   logic [TAM_DATA-1:0]  i_debug_read;
   logic                 i_tx_ready = 1'b1;
   logic [NUM_DIREC-1:0] o_debug_pointer;
   logic [7:0]           o_tx_data;
   logic                 o_tx_valid;
   logic                 o_busy;
   logic                 o_done;

   logic [TAM_DATA-1:0]  mem [0:127];

   mem_dump_sequencer #(
      .TAM_DATA (TAM_DATA),
      .NUM_BYTES(NUM_BYTES),
      .NUM_DIREC(NUM_DIREC)
   ) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_start        (i_start),
      .i_last_addr    (i_last_addr),
      .i_debug_read   (i_debug_read),
      .o_debug_pointer(o_debug_pointer),
      .o_tx_data      (o_tx_data),
      .o_tx_valid     (o_tx_valid),
      .i_tx_ready     (i_tx_ready),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   assign i_debug_read = mem[o_debug_pointer];
   always #5 i_clk = ~i_clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] got[$];
   logic [7:0] exp_b[$];
   int         done_idx, hold_viol, wrap_viol;
   logic       done_after, busy_after;
   logic [6:0] last_ptr;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start_dump(input logic [6:0] last);
      i_last_addr = last;
      i_start     = 1'b1;
      tick();
      i_start     = 1'b0;
   endtask

   task automatic add_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) exp_b.push_back(8'((w >> (8*b)) & 32'hFF));
   endtask

   task automatic add_csum();
      logic [7:0] x;
      x = 8'h00;
      foreach (exp_b[i]) x = x ^ exp_b[i];
      if (CS != 0) exp_b.push_back(x);
   endtask

   function automatic int diff_count();
      int bad;
      bad = (got.size() != exp_b.size()) ? 1 : 0;
      foreach (exp_b[i]) if (i >= got.size() || got[i] !== exp_b[i]) bad++;
      return bad;
   endfunction

   // Runs from cycle 1 (just after the start edge) until the cycle after o_done.
   task automatic run_dump(input int max_c, input bit bp);
      logic       pend;
      logic [7:0] pdata;
      logic [6:0] prev_ptr;
      got.delete();
      done_idx = 0; hold_viol = 0; wrap_viol = 0;
      done_after = 1'b1; busy_after = 1'b1;
      pend = 1'b0; pdata = 8'h00; prev_ptr = o_debug_pointer; last_ptr = '0;
      for (int c = 1; c <= max_c; c++) begin
         i_tx_ready = bp ? ((c % 4 == 1) || (c % 4 == 0)) : 1'b1;
         if (pend && !(o_tx_valid && o_tx_data == pdata)) hold_viol++;
         pend  = o_tx_valid && !i_tx_ready;
         pdata = o_tx_data;
         if (o_busy && o_debug_pointer < prev_ptr) wrap_viol++;
         prev_ptr = o_debug_pointer;
         if (o_tx_valid && i_tx_ready) begin
            got.push_back(o_tx_data);
            last_ptr = o_debug_pointer;
         end
         if (done_idx != 0) begin
            done_after = o_done;
            busy_after = o_busy;
            break;
         end
         if (o_done) done_idx = c;
         tick();
      end
      i_tx_ready = 1'b1;
   endtask

   task automatic test_reset();
      #2 i_reset = 1'b1;
      #1;
      checks++;
      if ({o_busy, o_tx_valid, o_done, o_debug_pointer, o_tx_data} !== '0) begin
         errors++;
         $display("FAIL reset_init: outputs %b, need all 0",
                  {o_busy, o_tx_valid, o_done, o_debug_pointer, o_tx_data});
      end
      tick(); tick();
      i_reset = 1'b0;
      tick();
      mem[0] = 32'h11223344;
      start_dump(7'd0);
      tick();
      #2 i_reset = 1'b1;
      #1;
      checks++;
      if ({o_busy, o_tx_valid, o_done, o_debug_pointer, o_tx_data} !== '0) begin
         errors++;
         $display("FAIL reset_mid_byte: outputs %b, need all 0",
                  {o_busy, o_tx_valid, o_done, o_debug_pointer, o_tx_data});
      end
      tick();
      i_reset = 1'b0;
      tick();
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_busy: got %b need 0", o_busy);
      end
   endtask

   task automatic test_single_word();
      int bad;
      mem[0] = 32'h11223344;
      start_dump(7'd0);
      run_dump(40, 1'b0);
      exp_b.delete();
      add_word(32'h11223344);
      add_csum();
      bad = diff_count();
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL single_bytes: %0d mismatches over %0d bytes, need 0", bad, got.size());
      end
      checks++;
      if (done_idx != 7 + CS) begin
         errors++;
         $display("FAIL single_done_cycle: got %0d need %0d", done_idx, 7 + CS);
      end
      checks++;
      if ({done_after, busy_after} !== 2'b00) begin
         errors++;
         $display("FAIL single_done_pulse: done/busy after %b need 00", {done_after, busy_after});
      end
      checks++;
      if (o_debug_pointer !== 7'd0) begin
         errors++;
         $display("FAIL single_ptr_return: got %0d need 0", o_debug_pointer);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      mem[0] = 32'hDEADBEEF;
      mem[1] = 32'h01020304;
      start_dump(7'd1);
      run_dump(200, 1'b1);
      exp_b.delete();
      exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
      if (CS != 0) exp_b.push_back(8'h26);
      bad = diff_count();
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_bytes: %0d mismatches over %0d bytes, need 0", bad, got.size());
      end
      checks++;
      if (hold_viol != 0) begin
         errors++;
         $display("FAIL bp_hold: %0d stalls changed data/valid, need 0", hold_viol);
      end
      checks++;
      if (done_idx == 0 || done_after !== 1'b0) begin
         errors++;
         $display("FAIL bp_done: done_idx %0d done_after %b, need pulse", done_idx, done_after);
      end
   endtask

   task automatic test_full_range();
      int bad;
      exp_b.delete();
      for (int k = 0; k < 128; k++) begin
         mem[k] = 32'(k);
         add_word(32'(k));
      end
      add_csum();
      start_dump(7'd127);
      run_dump(1000, 1'b0);
      bad = diff_count();
      checks++;
      if (got.size() != 512 + CS) begin
         errors++;
         $display("FAIL full_count: got %0d bytes need %0d", got.size(), 512 + CS);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL full_bytes: %0d mismatches, need 0", bad);
      end
      checks++;
      if (last_ptr !== 7'd127) begin
         errors++;
         $display("FAIL full_last_ptr: got %0d need 127", last_ptr);
      end
      checks++;
      if (wrap_viol != 0) begin
         errors++;
         $display("FAIL full_wrap: pointer went backwards %0d times, need 0", wrap_viol);
      end
      checks++;
      if (done_idx != 6*128 + 1 + CS) begin
         errors++;
         $display("FAIL full_done_cycle: got %0d need %0d", done_idx, 6*128 + 1 + CS);
      end
   endtask

   task automatic test_start_busy_and_reset();
      int   bad;
      bit   reached;
      mem[0] = 32'hA3A2A1A0; mem[1] = 32'hB3B2B1B0;
      mem[2] = 32'hC3C2C1C0; mem[3] = 32'hD3D2D1D0;
      start_dump(7'd3);
      got.delete();
      reached = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         i_start     = (c == 3) || (c == 7);
         if (c == 3) i_last_addr = 7'd0;
         if (o_debug_pointer == 7'd2 && o_tx_valid) begin
            reached = 1'b1;
            break;
         end
         if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
         tick();
      end
      i_start = 1'b0;
      #2 i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      exp_b.delete();
      add_word(32'hA3A2A1A0);
      add_word(32'hB3B2B1B0);
      bad = diff_count();
      checks++;
      if (!reached || bad != 0) begin
         errors++;
         $display("FAIL busy_ignore_start: reached %b, %0d mismatches, need 1 and 0", reached, bad);
      end
      checks++;
      if ({o_busy, o_debug_pointer} !== 8'd0) begin
         errors++;
         $display("FAIL busy_after_reset: busy %b ptr %0d need 0 0", o_busy, o_debug_pointer);
      end
      start_dump(7'd0);
      run_dump(40, 1'b0);
      exp_b.delete();
      add_word(32'hA3A2A1A0);
      add_csum();
      bad = diff_count();
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL restart_word0: %0d mismatches, need 0", bad);
      end
      // Start held high through DONE is taken on the following IDLE cycle.
      i_last_addr = 7'd0;
      i_start = 1'b1;
      tick();
      for (int c = 0; c < 20 && !o_done; c++) tick();
      tick();
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL held_start_idle: busy %b need 0", o_busy);
      end
      tick();
      i_start = 1'b0;
      checks++;
      if (o_busy !== 1'b1) begin
         errors++;
         $display("FAIL held_start_accept: busy %b need 1", o_busy);
      end
      run_dump(40, 1'b0);
      checks++;
      if (done_idx != 7 + CS) begin
         errors++;
         $display("FAIL held_start_done: got %0d need %0d", done_idx, 7 + CS);
      end
   endtask

   initial begin
      for (int k = 0; k < 128; k++) mem[k] = '0;
      test_reset();
      test_single_word();
      test_backpressure();
      test_full_range();
      test_start_busy_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
